// File: rtl/octal_cap_pkg.sv
// Shared types and constants for the octal ADC capture sequencer.
package octal_cap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WLOCK,
      ST_SETTLE,
      ST_CAPT,
      ST_NEXT,
      ST_DONE
   } state_t;

   localparam int NUM_PAIRS = 4;
   localparam int SEL_W     = 3;
   localparam int PAIR_W    = $clog2(NUM_PAIRS);

   // Fixed channel-pair select for a scan step: {odd channel, even channel}.
   function automatic logic [2*SEL_W-1:0] pair_sel(input logic [PAIR_W-1:0] idx);
      logic [SEL_W-1:0] even_ch;
      even_ch = {idx, 1'b0};
      return {even_ch | 3'b001, even_ch};
   endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with synchronous clear and a zero flag.
module seq_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_reg <= '0;
      else if (clr)
         count_reg <= '0;
      else if (load)
         count_reg <= load_val;
      else if (en)
         count_reg <= count_reg - 1'b1;
   end

   assign count = count_reg;
   assign zero  = (count_reg == '0);

endmodule

// File: rtl/octal_capture_sequencer.sv
// Acquisition controller for the octal LVDS ADC capture path.
// Define OCTAL_SEQ_SCAN_EN to step through all four channel pairs.
module octal_capture_sequencer
   import octal_cap_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int SETTLE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dco_locked,
   input  logic             fco_locked,
   input  logic [2:0]       sel_a,
   input  logic [2:0]       sel_b,
   input  logic [CNT_W-1:0] sample_count,
   input  logic             fifo_full,
   output logic             wren,
   output logic [5:0]       cntrl_bits,
   output logic             busy,
   output logic             done,
   output logic             lock_err,
   output logic             stalled,
   output logic [1:0]       pair_idx
);

`ifdef OCTAL_SEQ_SCAN_EN
   localparam logic SCAN_EN = 1'b1;
`else
   localparam logic SCAN_EN = 1'b0;
`endif

   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t           state_reg;
   logic [CNT_W-1:0] len_reg;
   logic             capt_reg;
   logic [5:0]       cntrl_bits_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             lock_err_reg;
   logic             stalled_reg;
   logic [1:0]       pair_idx_reg;

   logic             locks_ok;
   logic             wr_ok;
   logic             advance;
   logic             last_word;
   logic             cnt_clr;
   logic [SET_W-1:0] settle_count;
   logic             settle_zero;
   logic [CNT_W-1:0] rem_count;
   logic             rem_zero;

   assign locks_ok = dco_locked & fco_locked;
   // Registered capture enable, gated in the same cycle by backpressure and lock.
   assign wr_ok     = capt_reg & ~fifo_full & locks_ok;
   assign advance   = SCAN_EN && (pair_idx_reg != 2'(NUM_PAIRS - 1));
   assign last_word = (state_reg == ST_CAPT) && wr_ok && (rem_count == CNT_W'(1));
   assign cnt_clr   = abort || (state_reg == ST_IDLE);

   seq_down_counter #(.W(SET_W)) u_settle_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .load     (locks_ok && ((state_reg == ST_WLOCK) || ((state_reg == ST_NEXT) && advance))),
      .load_val (SET_W'(SETTLE - 1)),
      .en       ((state_reg == ST_SETTLE) && (settle_count != '0)),
      .count    (settle_count),
      .zero     (settle_zero)
   );

   seq_down_counter #(.W(CNT_W)) u_sample_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .load     ((state_reg == ST_SETTLE) && settle_zero && locks_ok),
      .load_val (len_reg),
      .en       ((state_reg == ST_CAPT) && wr_ok && !rem_zero),
      .count    (rem_count),
      .zero     (rem_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         len_reg        <= '0;
         capt_reg       <= 1'b0;
         cntrl_bits_reg <= 6'b000_000;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         lock_err_reg   <= 1'b0;
         stalled_reg    <= 1'b0;
         pair_idx_reg   <= 2'd0;
      end else begin
         done_reg <= 1'b0;
         if (abort) begin
            state_reg <= ST_IDLE;
            capt_reg  <= 1'b0;
            busy_reg  <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (start) begin
                     len_reg      <= sample_count;
                     lock_err_reg <= 1'b0;
                     stalled_reg  <= 1'b0;
                     pair_idx_reg <= 2'd0;
                     busy_reg     <= 1'b1;
                     if (sample_count == '0) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                     end else begin
                        cntrl_bits_reg <= {sel_b, sel_a};
                        state_reg      <= ST_WLOCK;
                     end
                  end
               end
               ST_WLOCK: begin
                  if (locks_ok)
                     state_reg <= ST_SETTLE;
               end
               ST_SETTLE, ST_CAPT, ST_NEXT: begin
                  if (!locks_ok) begin
                     lock_err_reg <= 1'b1;
                     capt_reg     <= 1'b0;
                     busy_reg     <= 1'b0;
                     state_reg    <= ST_IDLE;
                  end else if (state_reg == ST_SETTLE) begin
                     if (settle_zero) begin
                        capt_reg  <= 1'b1;
                        state_reg <= ST_CAPT;
                     end
                  end else if (state_reg == ST_CAPT) begin
                     if (fifo_full)
                        stalled_reg <= 1'b1;
                     if (last_word) begin
                        capt_reg  <= 1'b0;
                        state_reg <= ST_NEXT;
                     end
                  end else if (advance) begin
                     pair_idx_reg   <= pair_idx_reg + 2'd1;
                     cntrl_bits_reg <= pair_sel(pair_idx_reg + 2'd1);
                     state_reg      <= ST_SETTLE;
                  end else begin
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
               default: begin
                  capt_reg  <= 1'b0;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign wren       = wr_ok;
   assign cntrl_bits = cntrl_bits_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign lock_err   = lock_err_reg;
   assign stalled    = stalled_reg;
   assign pair_idx   = pair_idx_reg;

endmodule

// File: tb/tb_octal_capture_sequencer.sv
// Directed testbench for octal_capture_sequencer (single-pair or scan build).
module tb_octal_capture_sequencer;

`ifdef OCTAL_SEQ_SCAN_EN
   localparam int NP = 4;
`else
   localparam int NP = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        dco_locked = 1'b1;
   logic        fco_locked = 1'b1;
   logic [2:0]  sel_a = 3'd0;
   logic [2:0]  sel_b = 3'd0;
   logic [15:0] sample_count = 16'd0;
   logic        fifo_full = 1'b0;
   logic        wren;
   logic [5:0]  cntrl_bits;
   logic        busy;
   logic        done;
   logic        lock_err;
   logic        stalled;
   logic [1:0]  pair_idx;

   octal_capture_sequencer #(.CNT_W(16), .SETTLE(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .dco_locked   (dco_locked),
      .fco_locked   (fco_locked),
      .sel_a        (sel_a),
      .sel_b        (sel_b),
      .sample_count (sample_count),
      .fifo_full    (fifo_full),
      .wren         (wren),
      .cntrl_bits   (cntrl_bits),
      .busy         (busy),
      .done         (done),
      .lock_err     (lock_err),
      .stalled      (stalled),
      .pair_idx     (pair_idx)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   start_cyc = 0;
   logic mon_clr = 1'b0;

   int       wr_cnt, first_wr, last_wr, done_cnt, done_cyc, fall_cyc, ff_wr;
   logic     busy_prev;
   logic [5:0] pair_cb [4];

   always @(posedge clk) cyc <= cyc + 1;

   // Observer: samples DUT outputs mid-cycle, inputs change just after posedge.
   always @(negedge clk) begin
      if (mon_clr) begin
         wr_cnt <= 0; first_wr <= 0; last_wr <= 0; done_cnt <= 0;
         done_cyc <= 0; fall_cyc <= 0; ff_wr <= 0; busy_prev <= 1'b0;
         for (int k = 0; k < 4; k++) pair_cb[k] <= 6'h3f;
      end else begin
         if (wren === 1'b1) begin
            if (wr_cnt == 0) first_wr <= cyc;
            last_wr <= cyc;
            wr_cnt  <= wr_cnt + 1;
            pair_cb[pair_idx] <= cntrl_bits;
            if (fifo_full) ff_wr <= ff_wr + 1;
         end
         if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (busy_prev && !busy) fall_cyc <= cyc;
         busy_prev <= busy;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk); #1;
      mon_clr = 1'b1;
      @(negedge clk); #1;
      mon_clr = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] len);
      @(posedge clk); #1;
      start = 1'b1;
      sample_count = len;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      @(negedge clk); #1;
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic wait_writes(input int target);
      int n;
      n = 0;
      while (wr_cnt < target && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (wr_cnt < target) check("wait_writes_timeout", wr_cnt, target);
   endtask

   logic [5:0] exp_cb;

   initial begin
      #1 rst_n = 1'b0;
      mon_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wren", wren, 0);
      check("rst_cntrl", cntrl_bits, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_lock_err", lock_err, 0);
      check("rst_stalled", stalled, 0);
      check("rst_pair_idx", pair_idx, 0);
      rst_n = 1'b1;
      mon_clr = 1'b0;

      // Basic single acquisition, sel_a=2 sel_b=5
      sel_a = 3'd2; sel_b = 3'd5;
      clear_mon();
      do_start(16'd8);
      check("basic_cntrl", cntrl_bits, 6'b101_010);
      check("basic_busy", busy, 1);
      wait_idle("basic");
      check("basic_latency", first_wr - start_cyc, 6);
      check("basic_writes", wr_cnt, 8 * NP);
      check("basic_done_cnt", done_cnt, 1);
      check("basic_done_after_last", done_cyc - last_wr, 2);
      check("basic_busy_fall", fall_cyc - done_cyc, 1);
      check("basic_stalled", stalled, 0);

      // Pair selection, len=3
      sel_a = 3'd0; sel_b = 3'd0;
      clear_mon();
      do_start(16'd3);
      wait_idle("scan");
      check("scan_writes", wr_cnt, 3 * NP);
      check("scan_done_cnt", done_cnt, 1);
      for (int k = 0; k < NP; k++) begin
         exp_cb = (k == 0) ? 6'b000_000 : {3'(2 * k + 1), 3'(2 * k)};
         check($sformatf("scan_cb%0d", k), pair_cb[k], exp_cb);
      end

      // Backpressure: fifo_full for 5 cycles mid-capture
      clear_mon();
      do_start(16'd10);
      wait_writes(3);
      fifo_full = 1'b1;
      #2 check("stall_wren_low", wren, 0);
      repeat (5) @(posedge clk);
      #1 fifo_full = 1'b0;
      wait_idle("stall");
      check("stall_writes", wr_cnt, 10 * NP);
      check("stall_ff_wr", ff_wr, 0);
      check("stall_flag", stalled, 1);
      check("stall_done_cnt", done_cnt, 1);

      // Lock loss after 4 writes
      clear_mon();
      do_start(16'd8);
      wait_writes(4);
      fco_locked = 1'b0;
      #2 check("lock_wren_same_cycle", wren, 0);
      wait_idle("lock");
      check("lock_err_set", lock_err, 1);
      check("lock_writes", wr_cnt, 4);
      check("lock_done_cnt", done_cnt, 0);
      fco_locked = 1'b1;

      // Zero-length acquisition; also clears lock_err
      clear_mon();
      do_start(16'd0);
      check("zero_lock_err_clr", lock_err, 0);
      check("zero_done", done, 1);
      wait_idle("zero");
      check("zero_writes", wr_cnt, 0);
      check("zero_done_cnt", done_cnt, 1);

      // Abort during capture
      clear_mon();
      do_start(16'd8);
      wait_writes(2);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_wren", wren, 0);
      check("abort_busy", busy, 0);
      check("abort_writes", wr_cnt, 3);
      check("abort_done_cnt", done_cnt, 0);
      clear_mon();
      do_start(16'd5);
      wait_idle("post_abort");
      check("post_abort_latency", first_wr - start_cyc, 6);
      check("post_abort_writes", wr_cnt, 5 * NP);
      check("post_abort_done_cnt", done_cnt, 1);

      // Reset during capture
      clear_mon();
      do_start(16'd8);
      wait_writes(2);
      rst_n = 1'b0;
      #1;
      check("rst_mid_wren", wren, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_cntrl", cntrl_bits, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_mon();
      do_start(16'd4);
      wait_idle("post_rst");
      check("post_rst_writes", wr_cnt, 4 * NP);
      check("post_rst_done_cnt", done_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
